// File: rtl/spi_reg_pkg.sv
// Shared widths, command-byte layout, FSM encoding and the debug view of the
// SPI register bridge.
package spi_reg_pkg;

  localparam int REGNUM_W      = 7;
  localparam int DATA_W        = 8;
  localparam int CNT_W         = 3;
  localparam int CMD_WRITE_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } spi_state_e;

  // Observation bundle: FSM state, bit counter and the synchronised pin view.
  typedef struct packed {
    spi_state_e       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             ss_s;
    logic             sclk_s;
    logic             frame_end;
  } spi_dbg_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus single-cycle rise/fall
// pulses derived from the synchronised level. STAGES must be at least 2.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchroniser and remember the last settled level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns serial command/data bytes into single-cycle
// register-file strobes in the clk domain. sclk is only ever oversampled.
//
// Downstream strobe semantics: write is high for exactly one clk while
// regnum/regdata_write hold the target and data; read is high for exactly one
// clk while regdata_read (for the current regnum) is being captured for
// transmission. There is no back-pressure: the register file must accept
// every strobe in the cycle it is issued.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_INC    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ss,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  output logic [REGNUM_W-1:0] regnum,
  input  logic [DATA_W-1:0]   regdata_read,
  output logic [DATA_W-1:0]   regdata_write,
  output logic                read,
  output logic                write,
  output spi_dbg_t            dbg
);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-2:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rx_byte;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REGNUM_W-1:0] regnum_q, regnum_d;
  logic                write_q, write_d;
  logic                load1_q, load1_d;
  logic                load2_q, load2_d;

  // ss idles high, so its synchroniser resets high to avoid a false frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (ss),
    .level_o (ss_s),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sclk),
    .level_o (sclk_s),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // mosi uses the same depth as sclk so it is sampled at the detected rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      wdata_q  <= '0;
      regnum_q <= '0;
      write_q  <= 1'b0;
      load1_q  <= 1'b0;
      load2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      wdata_q  <= wdata_d;
      regnum_q <= regnum_d;
      write_q  <= write_d;
      load1_q  <= load1_d;
      load2_q  <= load2_d;
    end
  end

  // Next-state: byte assembly, command decode, strobes and the tx pipeline.
  // A read load is two clks behind byte completion: load1 lets regnum settle,
  // load2 is the capture cycle (and the read strobe).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    wdata_d  = wdata_q;
    regnum_d = regnum_q;
    write_d  = 1'b0;
    load1_d  = 1'b0;
    load2_d  = 1'b0;
    rx_byte  = {rx_q, mosi_s};

    // Post-write auto-increment happens even if ss rises right after the byte.
    if (AUTO_INC && write_q) begin
      regnum_d = regnum_q + REGNUM_W'(1);
    end

    if (ss_s) begin
      // Deselected (also wins over a byte completing in the same clk):
      // drop any partial byte and any pending read load.
      state_d = IDLE;
      cnt_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = ADDR;
        cnt_d   = '0;
        rx_d    = '0;
        tx_d    = '0;
      end
    end else begin
      load2_d = load1_q;
      if (load2_q) begin
        tx_d = regdata_read;
      end else if (sclk_fall && (cnt_q != '0)) begin
        tx_d = {tx_q[DATA_W-2:0], 1'b0};
      end

      if (sclk_rise) begin
        rx_d  = rx_byte[DATA_W-2:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) begin
          unique case (state_q)
            ADDR: begin
              regnum_d = rx_byte[REGNUM_W-1:0];
              if (rx_byte[CMD_WRITE_BIT]) begin
                state_d = WR;
              end else begin
                state_d = RD;
                load1_d = 1'b1;
              end
            end
            WR: begin
              wdata_d = rx_byte;
              write_d = 1'b1;
            end
            RD: begin
              if (AUTO_INC) begin
                regnum_d = regnum_q + REGNUM_W'(1);
              end
              load1_d = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign miso          = (state_q == RD) ? tx_q[DATA_W-1] : 1'b0;
  assign regnum        = regnum_q;
  assign regdata_write = wdata_q;
  assign write         = write_q;
  assign read          = load2_q;

  assign dbg = '{state: state_q, bit_cnt: cnt_q, ss_s: ss_s, sclk_s: sclk_s,
                 frame_end: ss_rise};

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: a bit-level SPI master, a register-file read
// model, and a scoreboard of expected write/read strobes and miso bytes.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  localparam int HALF = 6;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi, miso, read, write;
  logic [6:0] regnum;
  logic [7:0] regdata_read, regdata_write;
  spi_dbg_t   dbg;

  int total = 0;
  int bad   = 0;

  logic [14:0] exp_wr_q[$];    // {regnum, data} per expected write strobe
  logic [6:0]  exp_rd_q[$];    // regnum per expected read strobe
  logic [7:0]  exp_miso_q[$];  // byte the master should shift in
  logic [7:0]  frame_q[$];     // bytes the master sends in the next frame
  logic [6:0]  exp_regnum;
  logic [14:0] wr_exp;
  logic [6:0]  rd_exp;

  always #5 clk = ~clk;

  // Register-file read model: combinational from regnum.
  function automatic logic [7:0] rd_model(input logic [6:0] r);
    if (r == 7'h00) return 8'h17;
    return {r, 1'b1} ^ 8'h80;
  endfunction

  assign regdata_read = rd_model(regnum);

  spi_reg_bridge #(.SYNC_STAGES(2), .AUTO_INC(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .ss            (ss),
    .sclk          (sclk),
    .mosi          (mosi),
    .miso          (miso),
    .regnum        (regnum),
    .regdata_read  (regdata_read),
    .regdata_write (regdata_write),
    .read          (read),
    .write         (write),
    .dbg           (dbg)
  );

  // Scoreboard: every strobe must match the head of its expected queue.
  always @(negedge clk) begin
    if (!rst && write) begin
      total++;
      if (exp_wr_q.size() == 0) begin
        bad++;
        $display("FAIL write_strobe: unexpected pulse regnum=%h data=%h", regnum, regdata_write);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        if ({regnum, regdata_write} !== wr_exp) begin
          bad++;
          $display("FAIL write_strobe: got regnum=%h data=%h expected regnum=%h data=%h",
                   regnum, regdata_write, wr_exp[14:8], wr_exp[7:0]);
        end
      end
    end
    if (!rst && read) begin
      total++;
      if (exp_rd_q.size() == 0) begin
        bad++;
        $display("FAIL read_strobe: unexpected pulse regnum=%h", regnum);
      end else begin
        rd_exp = exp_rd_q.pop_front();
        if (regnum !== rd_exp) begin
          bad++;
          $display("FAIL read_strobe: got regnum=%h expected %h", regnum, rd_exp);
        end
      end
    end
  end

  // Expected behaviour of frame_q. A frame ends with ss rising one clk after
  // the last sclk rise, so a read reload after the final full byte never fires;
  // an aborted frame ends slowly, so the reload after the last full byte does.
  task automatic model_frame(input int abort_bits);
    int         nfull;
    logic [6:0] r;
    logic       wr;
    nfull = (abort_bits > 0) ? frame_q.size() - 1 : frame_q.size();
    r     = frame_q[0][6:0];
    wr    = frame_q[0][7];
    exp_miso_q.push_back(8'h00);
    if (!wr && (nfull > 1 || abort_bits > 0)) exp_rd_q.push_back(r);
    for (int k = 1; k < nfull; k++) begin
      if (wr) begin
        exp_wr_q.push_back({r, frame_q[k]});
        exp_miso_q.push_back(8'h00);
      end else begin
        exp_miso_q.push_back(rd_model(r));
      end
      r = r + 7'd1;
      if (!wr && (k < nfull - 1 || abort_bits > 0)) exp_rd_q.push_back(r);
    end
    exp_regnum = r;
  endtask

  // One sclk cycle: drive mosi in the low phase, sample miso at the rise.
  task automatic spi_bit(input logic b, input int hold, output logic m);
    sclk = 1'b0;
    mosi = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    m = miso;
    repeat (hold) @(negedge clk);
  endtask

  // Send frame_q; abort_bits > 0 truncates the last byte to that many bits.
  task automatic spi_frame(input int abort_bits, input int gap);
    logic       m;
    logic [7:0] got, e;
    int         nbytes, nb;
    nbytes = frame_q.size();
    @(negedge clk);
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      nb  = (abort_bits > 0 && i == nbytes - 1) ? abort_bits : 8;
      got = '0;
      for (int j = 0; j < nb; j++) begin
        spi_bit(frame_q[i][7-j], (i == nbytes - 1 && j == 7) ? 1 : HALF, m);
        got = {got[6:0], m};
      end
      if (nb == 8) begin
        total++;
        if (exp_miso_q.size() == 0) begin
          bad++;
          $display("FAIL miso_byte: byte %0d got %h with no expectation", i, got);
        end else begin
          e = exp_miso_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL miso_byte: byte %0d got %h expected %h", i, got, e);
          end
        end
      end
    end
    ss = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    spi_dbg_t exp_dbg;
    exp_dbg = '{state: IDLE, bit_cnt: 3'd0, ss_s: 1'b1, sclk_s: 1'b0, frame_end: 1'b0};
    repeat (3) @(negedge clk);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b expected 0", miso); end
    total++; if (regnum !== 7'h00) begin bad++; $display("FAIL reset_regnum: got %h expected 00", regnum); end
    total++; if (regdata_write !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h expected 00", regdata_write); end
    total++; if ({read, write} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got read=%b write=%b expected 0 0", read, write); end
    total++; if (dbg !== exp_dbg) begin bad++; $display("FAIL reset_dbg: got %h expected %h", dbg, exp_dbg); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (dbg !== exp_dbg) begin bad++; $display("FAIL idle_after_reset: got %h expected %h", dbg, exp_dbg); end
  endtask

  task automatic test_single_write();
    frame_q = '{8'h81, 8'hA5};
    model_frame(0);
    spi_frame(0, HALF);
    total++; if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin bad++; $display("FAIL single_write_pending: got wr=%0d rd=%0d expected 0 0", exp_wr_q.size(), exp_rd_q.size()); end
    total++; if (regnum !== exp_regnum) begin bad++; $display("FAIL single_write_regnum: got %h expected %h", regnum, exp_regnum); end
  endtask

  task automatic test_single_read();
    frame_q = '{8'h00, 8'h00};
    model_frame(0);
    spi_frame(0, HALF);
    total++; if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin bad++; $display("FAIL single_read_pending: got wr=%0d rd=%0d expected 0 0", exp_wr_q.size(), exp_rd_q.size()); end
    total++; if (regnum !== exp_regnum) begin bad++; $display("FAIL single_read_regnum: got %h expected %h", regnum, exp_regnum); end
  endtask

  task automatic test_burst_write();
    frame_q = '{8'h81, 8'h11, 8'h22};
    model_frame(0);
    spi_frame(0, HALF);
    total++; if (exp_wr_q.size() != 0) begin bad++; $display("FAIL burst_pending: got %0d expected 0", exp_wr_q.size()); end
    total++; if (regnum !== 7'h03) begin bad++; $display("FAIL burst_regnum: got %h expected 03", regnum); end
  endtask

  task automatic test_wrap();
    frame_q = '{8'hFF, 8'hAA, 8'hBB};
    model_frame(0);
    spi_frame(0, HALF);
    total++; if (exp_wr_q.size() != 0) begin bad++; $display("FAIL wrap_pending: got %0d expected 0", exp_wr_q.size()); end
    total++; if (regnum !== 7'h01) begin bad++; $display("FAIL wrap_regnum: got %h expected 01", regnum); end
  endtask

  task automatic test_abort();
    frame_q = '{8'h81, 8'hF0};
    model_frame(4);
    spi_frame(4, HALF);
    total++; if (dbg.state !== IDLE || dbg.bit_cnt !== 3'd0) begin bad++; $display("FAIL abort_state: got state=%0d cnt=%0d expected 0 0", dbg.state, dbg.bit_cnt); end
    total++; if (regnum !== exp_regnum) begin bad++; $display("FAIL abort_regnum: got %h expected %h", regnum, exp_regnum); end
    frame_q = '{8'h85, 8'h3C};
    model_frame(0);
    spi_frame(0, HALF);
    total++; if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin bad++; $display("FAIL abort_next_pending: got wr=%0d rd=%0d expected 0 0", exp_wr_q.size(), exp_rd_q.size()); end
    total++; if (regnum !== 7'h06) begin bad++; $display("FAIL abort_next_regnum: got %h expected 06", regnum); end
  endtask

  task automatic test_back_to_back();
    frame_q = '{8'h10, 8'h00, 8'h00, 8'h00};
    model_frame(0);
    spi_frame(0, 2);
    total++; if (regnum !== 7'h13) begin bad++; $display("FAIL b2b_read_regnum: got %h expected 13", regnum); end
    frame_q = '{8'hA0, 8'h44};
    model_frame(0);
    spi_frame(0, HALF);
    total++; if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin bad++; $display("FAIL b2b_pending: got wr=%0d rd=%0d expected 0 0", exp_wr_q.size(), exp_rd_q.size()); end
    total++; if (regnum !== 7'h21) begin bad++; $display("FAIL b2b_regnum: got %h expected 21", regnum); end
  endtask

  task automatic test_reset_mid_read();
    logic       m;
    logic [7:0] cmd;
    cmd = 8'h05;
    exp_rd_q.push_back(7'h05);
    @(negedge clk);
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int j = 0; j < 8; j++) spi_bit(cmd[7-j], HALF, m);
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    total++; if (miso !== 1'b1) begin bad++; $display("FAIL mid_read_miso_before: got %b expected 1", miso); end
    total++; if (regnum !== 7'h05) begin bad++; $display("FAIL mid_read_regnum_before: got %h expected 05", regnum); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({miso, read, write} !== 3'b000) begin bad++; $display("FAIL mid_read_async_outputs: got miso=%b read=%b write=%b expected 0 0 0", miso, read, write); end
    total++; if (regnum !== 7'h00 || dbg.state !== IDLE) begin bad++; $display("FAIL mid_read_async_regnum: got regnum=%h state=%0d expected 00 0", regnum, dbg.state); end
    @(negedge clk);
    rst = 1'b0;
    ss  = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (exp_rd_q.size() != 0) begin bad++; $display("FAIL mid_read_pending: got %0d expected 0", exp_rd_q.size()); end
    frame_q = '{8'h81, 8'h5A};
    model_frame(0);
    spi_frame(0, HALF);
    total++; if (exp_wr_q.size() != 0) begin bad++; $display("FAIL post_reset_write_pending: got %0d expected 0", exp_wr_q.size()); end
    total++; if (regnum !== 7'h02) begin bad++; $display("FAIL post_reset_regnum: got %h expected 02", regnum); end
  endtask

  initial begin
    rst  = 1'b1;
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
